// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared button state encoding and default timing constants
//
// Purpose: state encoding for the button event classifier and the default
// timing constants shared by the debouncer and the event classifier.
// Ports: none (package).

package button_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE    = 2'd0,
    BTN_PRESSED = 2'd1,
    BTN_LONG    = 2'd2
  } btn_state_e;

  // Defaults assume a 100 MHz system clock.
  localparam int BTN_DEBOUNCE_TIME = 2_000_000;    // 20 ms
  localparam int BTN_LONG_TIME     = 100_000_000;  // 1 s
  localparam int BTN_REPEAT_TIME   = 20_000_000;   // 200 ms

endpackage

// File: rtl/my_button_event.sv
// rtl/my_button_event.sv - classifies debounced presses into short, long and repeat pulses
//
// Purpose: turns the debounced button level into 1-clock event pulses:
//   short  - released before the hold reached LONG_TIME clocks
//   long   - hold reached LONG_TIME clocks
//   repeat - every REPEAT_TIME clocks after the long event while still held
// Ports:
//   i_clk          system clock
//   i_reset_n      synchronous reset, active low
//   i_btn          debounced, clock-synchronous button level (1 = pressed)
//   o_held         1 while a press is in progress
//   o_short_pulse  1-clock pulse on release of a short press
//   o_long_pulse   1-clock pulse when the hold reaches LONG_TIME
//   o_repeat_pulse 1-clock pulse every REPEAT_TIME clocks after the long event

module my_button_event
  import button_pkg::*;
#(
  parameter int LONG_TIME   = BTN_LONG_TIME,
  parameter int REPEAT_TIME = BTN_REPEAT_TIME,
  parameter bit REPEAT_EN   = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_btn,
  output logic o_held,
  output logic o_short_pulse,
  output logic o_long_pulse,
  output logic o_repeat_pulse
);

  localparam int MAX_TIME = (LONG_TIME > REPEAT_TIME) ? LONG_TIME : REPEAT_TIME;
  localparam int CNT_W    = $clog2(MAX_TIME);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TIME - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TIME - 1);

  btn_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_held;
  logic             r_short_pulse;
  logic             r_long_pulse;
  logic             r_repeat_pulse;

  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // State, counter and output registers share one process so every output
  // is registered alongside the state transition that produces it.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state        <= BTN_IDLE;
      r_cnt          <= '0;
      r_held         <= 1'b0;
      r_short_pulse  <= 1'b0;
      r_long_pulse   <= 1'b0;
      r_repeat_pulse <= 1'b0;
    end else begin
      r_short_pulse  <= 1'b0;
      r_long_pulse   <= 1'b0;
      r_repeat_pulse <= 1'b0;

      case (r_state)
        BTN_IDLE: begin
          if (i_btn) begin
            r_state <= BTN_PRESSED;
            r_cnt   <= '0;
            r_held  <= 1'b1;
          end
        end

        BTN_PRESSED: begin
          // Release wins over the long timeout landing on the same edge.
          if (!i_btn) begin
            r_state       <= BTN_IDLE;
            r_cnt         <= '0;
            r_held        <= 1'b0;
            r_short_pulse <= 1'b1;
          end else if (r_cnt == LONG_LAST) begin
            r_state      <= BTN_LONG;
            r_cnt        <= '0;
            r_long_pulse <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        BTN_LONG: begin
          if (!i_btn) begin
            r_state <= BTN_IDLE;
            r_cnt   <= '0;
            r_held  <= 1'b0;
          end else if (REPEAT_EN && (r_cnt == REPEAT_LAST)) begin
            r_cnt          <= '0;
            r_repeat_pulse <= 1'b1;
          end else if (REPEAT_EN) begin
            r_cnt <= w_cnt_inc;
          end
        end

        default: begin
          r_state <= BTN_IDLE;
          r_cnt   <= '0;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign o_held         = r_held;
  assign o_short_pulse  = r_short_pulse;
  assign o_long_pulse   = r_long_pulse;
  assign o_repeat_pulse = r_repeat_pulse;

endmodule

// File: tb/tb_my_button_event.sv
// tb/tb_my_button_event.sv - scoreboard bench for my_button_event

module tb_my_button_event;

  localparam int L = 10;
  localparam int R = 4;

  typedef struct {
    int edge_n;
    int kind;   // 0 short, 1 long, 2 repeat
  } ev_t;

  logic clk = 1'b0;
  logic rstn;
  logic btn;
  logic h0, s0, l0, r0;
  logic h1, s1, l1, r1;

  int  edge_no = 0;
  int  checks  = 0;
  int  errors  = 0;
  bit  done    = 1'b0;
  bit  active  = 1'b0;
  int  k       = 0;

  ev_t q0[$];
  ev_t q1[$];
  bit  exp_held[int];

  my_button_event #(.LONG_TIME(L), .REPEAT_TIME(R), .REPEAT_EN(1'b1)) dut_rep (
    .i_clk(clk), .i_reset_n(rstn), .i_btn(btn),
    .o_held(h0), .o_short_pulse(s0), .o_long_pulse(l0), .o_repeat_pulse(r0)
  );

  my_button_event #(.LONG_TIME(L), .REPEAT_TIME(R), .REPEAT_EN(1'b0)) dut_norep (
    .i_clk(clk), .i_reset_n(rstn), .i_btn(btn),
    .o_held(h1), .o_short_pulse(s1), .o_long_pulse(l1), .o_repeat_pulse(r1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_no <= edge_no + 1;

  task automatic push(input int id, input int e, input int kind);
    ev_t ev;
    ev.edge_n = e;
    ev.kind   = kind;
    if (id == 0) q0.push_back(ev);
    else         q1.push_back(ev);
  endtask

  // Drives one cycle of stimulus and records what the reference model
  // expects at the edge that will sample it. The model only tracks how long
  // the current press has lasted and derives events from that age.
  task automatic step(input logic b, input logic rn);
    int e;
    int age;
    @(negedge clk);
    btn  = b;
    rstn = rn;
    e    = edge_no + 1;
    if (!rn) begin
      active = 1'b0;
    end else if (b) begin
      if (!active) begin
        active = 1'b1;
        k      = e;
      end
      age         = e - k;
      exp_held[e] = 1'b1;
      if (age == L) begin
        push(0, e, 1);
        push(1, e, 1);
      end else if (age > L && ((age - L) % R) == 0) begin
        push(0, e, 2);
      end
    end else if (active) begin
      age    = e - k;
      active = 1'b0;
      if (age <= L) begin
        push(0, e, 0);
        push(1, e, 0);
      end
    end
  endtask

  task automatic press(input int d, input int gap);
    repeat (d) step(1'b1, 1'b1);
    repeat (gap) step(1'b0, 1'b1);
  endtask

  task automatic mon(input int id, input logic s, input logic l, input logic r);
    int  n;
    int  kind;
    bit  have;
    ev_t f;
    n    = int'(s) + int'(l) + int'(r);
    kind = s ? 0 : (l ? 1 : 2);
    have = 1'b0;
    f.edge_n = 0;
    f.kind   = 0;
    if (id == 0 && q0.size() > 0) begin have = 1'b1; f = q0[0]; end
    if (id == 1 && q1.size() > 0) begin have = 1'b1; f = q1[0]; end

    if (n > 0) begin
      checks++;
      if (n > 1) begin
        errors++;
        $display("FAIL dut%0d one_hot edge %0d got %0d pulses want 1", id, edge_no, n);
      end
    end

    if (n > 0 || (have && f.edge_n <= edge_no)) begin
      checks++;
      if (n == 0) begin
        errors++;
        $display("FAIL dut%0d missed_event edge %0d got none want kind %0d at edge %0d",
                 id, edge_no, f.kind, f.edge_n);
      end else if (!have || f.edge_n != edge_no || f.kind != kind) begin
        errors++;
        $display("FAIL dut%0d event edge %0d got kind %0d want kind %0d at edge %0d (queued=%0d)",
                 id, edge_no, kind, f.kind, f.edge_n, have);
      end
      if (have && f.edge_n <= edge_no) begin
        if (id == 0) void'(q0.pop_front());
        else         void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    bit eh;
    if (edge_no >= 1 && !done) begin
      eh = exp_held.exists(edge_no) ? exp_held[edge_no] : 1'b0;
      checks++;
      if (h0 !== eh) begin
        errors++;
        $display("FAIL dut0 held edge %0d got %b want %b", edge_no, h0, eh);
      end
      checks++;
      if (h1 !== eh) begin
        errors++;
        $display("FAIL dut1 held edge %0d got %b want %b", edge_no, h1, eh);
      end
      mon(0, s0, l0, r0);
      mon(1, s1, l1, r1);
    end
  end

  initial begin
    int d;
    int m;
    rstn = 1'b0;
    btn  = 1'b1;

    // Reset held with the button down, then the hold counts as a new press.
    step(1'b1, 1'b0);
    press(3, 3);
    // Short press.
    press(3, 2);
    // Long press with three repeats, released without a short pulse.
    press(26, 3);
    // Release exactly at the long threshold gives a short press.
    press(10, 2);
    // One-clock press.
    press(1, 2);
    // Reset mid-hold with the button still down.
    repeat (12) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    press(15, 3);
    // Long hold: the no-repeat instance gives only the long pulse.
    press(30, 3);

    for (int i = 0; i < 60; i++) begin
      d = $urandom_range(1, 30);
      if ($urandom_range(0, 9) == 0) begin
        m = $urandom_range(1, d);
        repeat (m) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
      end
      press(d, $urandom_range(1, 4));
    end

    repeat (3) step(1'b0, 1'b1);
    @(negedge clk);
    #1;
    done = 1'b1;

    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL dut0 leftover got %0d pending events want 0", q0.size());
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL dut1 leftover got %0d pending events want 0", q1.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
